zap_intr_ctrl: RTL and testbench

//  Interrupt controller feeding the core's i_irq/i_fiq inputs and consuming o_irq_ack/o_fiq_ack.

---
 rtl/zap_intr_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_zap_intr_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/zap_intr_ctrl.sv
// Interrupt controller: synchronises NUM_SRC sources, masks/routes them to IRQ or FIQ, one request FSM per class.
// Optional ZAP_INTR_EDGE_EN selects edge-latched PENDING (default build: level mode).
module zap_intr_ctrl #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NUM_SRC-1:0] i_src,
  input  logic               i_reg_wr_en,
  input  logic [1:0]         i_reg_addr,
  input  logic [31:0]        i_reg_wdata,
  output logic [31:0]        o_reg_rdata,
  output logic               o_irq,
  input  logic               i_irq_ack,
  output logic [4:0]         o_irq_id,
  output logic               o_fiq,
  input  logic               i_fiq_ack,
  output logic [4:0]         o_fiq_id
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ASSERT  = 2'd1;
  localparam logic [1:0] S_ACK     = 2'd2;
  localparam logic [1:0] A_ENABLE  = 2'd0;
  localparam logic [1:0] A_FIQ_SEL = 2'd1;
  localparam logic [1:0] A_PENDING = 2'd2;
  localparam logic [1:0] A_RAW     = 2'd3;

  logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] r_fiq_sel;
  logic [NUM_SRC-1:0] r_pending;
  logic [31:0]        r_rdata;
  logic [1:0]         r_state [2];
  logic               r_req   [2];
  logic [4:0]         r_id    [2];

  logic [NUM_SRC-1:0] w_sync;
  logic [NUM_SRC-1:0] w_wdata;
  logic [NUM_SRC-1:0] w_active;
  logic [NUM_SRC-1:0] w_w1c;
  logic [NUM_SRC-1:0] w_pending_nxt;
  logic [NUM_SRC-1:0] w_cand     [2];
  logic [NUM_SRC-1:0] w_arb      [2];
  logic [NUM_SRC-1:0] w_ack_mask [2];
  logic               w_ack      [2];
  logic               w_unused;

  function automatic logic [4:0] f_lowest(input logic [NUM_SRC-1:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  function automatic logic f_bit_at(input logic [NUM_SRC-1:0] v, input logic [4:0] id);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id == 5'(i)) b = v[i];
    end
    return b;
  endfunction

  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_wdata     = i_reg_wdata[NUM_SRC-1:0];
  assign w_active    = r_pending & r_enable;
  assign w_cand[0]   = w_active & ~r_fiq_sel;
  assign w_cand[1]   = w_active & r_fiq_sel;
  assign w_ack[0]    = i_irq_ack;
  assign w_ack[1]    = i_fiq_ack;
  assign w_w1c       = (i_reg_wr_en && (i_reg_addr == A_PENDING)) ? w_wdata : {NUM_SRC{1'b0}};
  assign o_reg_rdata = r_rdata;
  assign o_irq       = r_req[0];
  assign o_irq_id    = r_id[0];
  assign o_fiq       = r_req[1];
  assign o_fiq_id    = r_id[1];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_ack_mask[k] = {NUM_SRC{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
        w_ack_mask[k][i] = (r_state[k] == S_ACK) && (r_id[k] == 5'(i));
      end
    end
  end

`ifdef ZAP_INTR_EDGE_EN
  logic [NUM_SRC-1:0] r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_prev <= {NUM_SRC{1'b0}};
    else            r_prev <= w_sync;
  end

  // A new rising edge wins over a W1C or ACK clear of the same bit.
  assign w_pending_nxt = (r_pending & ~w_w1c & ~w_ack_mask[0] & ~w_ack_mask[1]) | (w_sync & ~r_prev);
  assign w_arb[0]      = w_cand[0] & ~w_ack_mask[0];
  assign w_arb[1]      = w_cand[1] & ~w_ack_mask[1];
  assign w_unused      = ^i_reg_wdata;
`else
  assign w_pending_nxt = w_sync;
  assign w_arb[0]      = w_cand[0];
  assign w_arb[1]      = w_cand[1];
  assign w_unused      = ^{i_reg_wdata, w_w1c, w_ack_mask[0], w_ack_mask[1]};
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= {NUM_SRC{1'b0}};
    end else begin
      r_sync[0] <= i_src;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_enable  <= {NUM_SRC{1'b0}};
      r_fiq_sel <= {NUM_SRC{1'b0}};
      r_pending <= {NUM_SRC{1'b0}};
      r_rdata   <= 32'd0;
    end else begin
      r_pending <= w_pending_nxt;
      if (i_reg_wr_en && (i_reg_addr == A_ENABLE))  r_enable  <= w_wdata;
      if (i_reg_wr_en && (i_reg_addr == A_FIQ_SEL)) r_fiq_sel <= w_wdata;
      case (i_reg_addr)
        A_ENABLE:  r_rdata <= 32'(r_enable);
        A_FIQ_SEL: r_rdata <= 32'(r_fiq_sel);
        A_PENDING: r_rdata <= 32'(r_pending);
        A_RAW:     r_rdata <= 32'(w_sync);
        default:   r_rdata <= 32'd0;
      endcase
    end
  end

  // ACK re-arbitrates like IDLE, so a still-pending source returns after a single low cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int k = 0; k < 2; k++) begin
        r_state[k] <= S_IDLE;
        r_req[k]   <= 1'b0;
        r_id[k]    <= 5'd0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        case (r_state[k])
          S_IDLE, S_ACK: begin
            if (|w_arb[k]) begin
              r_state[k] <= S_ASSERT;
              r_req[k]   <= 1'b1;
              r_id[k]    <= f_lowest(w_arb[k]);
            end else begin
              r_state[k] <= S_IDLE;
              r_req[k]   <= 1'b0;
            end
          end
          S_ASSERT: begin
            if (w_ack[k]) begin
              r_state[k] <= S_ACK;
              r_req[k]   <= 1'b0;
            end else if (!f_bit_at(w_cand[k], r_id[k])) begin
              r_state[k] <= S_IDLE;
              r_req[k]   <= 1'b0;
            end else begin
              r_state[k] <= S_ASSERT;
              r_req[k]   <= 1'b1;
            end
          end
          default: begin
            r_state[k] <= S_IDLE;
            r_req[k]   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zap_intr_ctrl.sv
// Scoreboard bench for zap_intr_ctrl: expectations are queued with a due cycle and checked on the falling edge.
module tb_zap_intr_ctrl;

`ifdef ZAP_INTR_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  localparam int SEL_IRQ = 0, SEL_IRQ_ID = 1, SEL_FIQ = 2, SEL_FIQ_ID = 3, SEL_RDATA = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  src;
  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq, irq_ack, fiq, fiq_ack;
  logic [4:0]  irq_id, fiq_id;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  zap_intr_ctrl #(.NUM_SRC(8), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_src(src),
    .i_reg_wr_en(wr_en), .i_reg_addr(addr), .i_reg_wdata(wdata), .o_reg_rdata(rdata),
    .o_irq(irq), .i_irq_ack(irq_ack), .o_irq_id(irq_id),
    .o_fiq(fiq), .i_fiq_ack(fiq_ack), .o_fiq_id(fiq_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_IRQ:    return {31'd0, irq};
      SEL_IRQ_ID: return {27'd0, irq_id};
      SEL_FIQ:    return {31'd0, fiq};
      SEL_FIQ_ID: return {27'd0, fiq_id};
      default:    return rdata;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        check_val(sb_q[i].tag, observe(sb_q[i].sel), sb_q[i].exp);
        sb_q.delete(i);
      end
    end
  end

  task automatic push_exp(input string tag, input int sel, input logic [31:0] exp, input int dly);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp; e.due = cyc + dly;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic cleanup();
    src = 8'h00; irq_ack = 1'b0; fiq_ack = 1'b0;
    step(4);
    reg_wr(2'd0, 32'h0);
    reg_wr(2'd1, 32'h0);
    reg_wr(2'd2, 32'hFF);
    step(6);
  endtask

  initial begin
    int t;
    rst_n = 1'b0; src = 8'hFF; wr_en = 1'b1; addr = 2'd0; wdata = 32'hFF;
    irq_ack = 1'b0; fiq_ack = 1'b0;

    // Reset held 4 clocks with sources high and an ENABLE write attempted
    step(3);
    push_exp("rst_irq", SEL_IRQ, 32'd0, 0);
    push_exp("rst_fiq", SEL_FIQ, 32'd0, 0);
    push_exp("rst_rdata", SEL_RDATA, 32'd0, 0);
    step(1);
    rst_n = 1'b1; wr_en = 1'b0; addr = 2'd0;
    push_exp("rst_enable", SEL_RDATA, 32'd0, 1);
    step(4);
    addr = 2'd3;
    push_exp("raw_read", SEL_RDATA, 32'hFF, 1);
    step(2);
    cleanup();

    // Single IRQ, latency and ack
    reg_wr(2'd0, 32'h14);
    src = 8'h10; t = cyc;
    push_exp("irq_lat_lo", SEL_IRQ, 32'd0, 3);
    push_exp("irq_lat_hi", SEL_IRQ, 32'd1, 4);
    push_exp("irq_id4", SEL_IRQ_ID, 32'd4, 4);
    step(4);
    irq_ack = 1'b1;
    push_exp("irq_ack_lo", SEL_IRQ, 32'd0, 1);
    push_exp("irq_after_ack", SEL_IRQ, EDGE ? 32'd0 : 32'd1, 2);
    step(1);
    irq_ack = 1'b0;
    cleanup();

    // IRQ and FIQ together
    reg_wr(2'd0, 32'hFF);
    reg_wr(2'd1, 32'h01);
    push_exp("fiq_sel_rd", SEL_RDATA, 32'h01, 1);
    step(1);
    addr = 2'd0;
    push_exp("enable_rd", SEL_RDATA, 32'hFF, 1);
    src = 8'h81; t = cyc;
    push_exp("both_irq_lo", SEL_IRQ, 32'd0, 3);
    push_exp("both_fiq_lo", SEL_FIQ, 32'd0, 3);
    push_exp("both_irq", SEL_IRQ, 32'd1, 4);
    push_exp("both_irq_id", SEL_IRQ_ID, 32'd7, 4);
    push_exp("both_fiq", SEL_FIQ, 32'd1, 4);
    push_exp("both_fiq_id", SEL_FIQ_ID, 32'd0, 4);
    step(4);
    irq_ack = 1'b1; fiq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0; fiq_ack = 1'b0;
    cleanup();

    // PENDING behaviour: pulse, W1C, and a set coinciding with W1C
    src = 8'h04; t = cyc;
    step(3);
    src = 8'h00;
    step(5);
    addr = 2'd2;
    push_exp("pend_after_pulse", SEL_RDATA, EDGE ? 32'h04 : 32'h00, 1);
    step(1);
    reg_wr(2'd2, 32'h04);
    push_exp("pend_w1c", SEL_RDATA, 32'h00, 1);
    step(2);
    t = cyc;
    src = 8'h04;
    step(2);
    wr_en = 1'b1; addr = 2'd2; wdata = 32'h04;
    step(1);
    wr_en = 1'b0; src = 8'h00;
    push_exp("set_beats_w1c", SEL_RDATA, 32'h04, 2);
    push_exp("pend_hold", SEL_RDATA, EDGE ? 32'h04 : 32'h00, 5);
    step(6);
    cleanup();

    // Withdraw by masking, no ack
    reg_wr(2'd0, 32'h08);
    src = 8'h08;
    step(4);
    push_exp("wd_irq_hi", SEL_IRQ, 32'd1, 0);
    push_exp("wd_irq_id3", SEL_IRQ_ID, 32'd3, 0);
    wr_en = 1'b1; addr = 2'd0; wdata = 32'h0;
    push_exp("wd_irq_still", SEL_IRQ, 32'd1, 1);
    push_exp("wd_irq_lo", SEL_IRQ, 32'd0, 2);
    step(1);
    wr_en = 1'b0;
    step(2);
    cleanup();

    // Held source re-requests after the ACK gap in level mode
    reg_wr(2'd0, 32'h02);
    src = 8'h02;
    step(4);
    push_exp("lv_irq_hi", SEL_IRQ, 32'd1, 0);
    push_exp("lv_irq_id1", SEL_IRQ_ID, 32'd1, 0);
    irq_ack = 1'b1;
    push_exp("lv_ack_gap", SEL_IRQ, 32'd0, 1);
    push_exp("lv_rereq", SEL_IRQ, EDGE ? 32'd0 : 32'd1, 2);
    push_exp("lv_rereq_id", SEL_IRQ_ID, 32'd1, 2);
    push_exp("lv_rereq_hold", SEL_IRQ, EDGE ? 32'd0 : 32'd1, 3);
    step(1);
    irq_ack = 1'b0;
    step(4);
    cleanup();

    step(2);
    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
